// File: rtl/pc_ctrl_unit.sv
// pc_ctrl_unit: program counter, START/RUN/HALT sequencing and decode of ADD, SUB, ADDI, BNE, EBREAK.
// Optional retired-instruction counter port is built when PC_CTRL_INSTR_COUNT_EN is defined.
module pc_ctrl_unit #(
    parameter int ADDR_WIDTH          = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH          = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          instr,
    input  logic                           Zero,
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
    output logic                           WE3,
    output logic                           ALUsrc,
    output logic                           ALUctrl,
    output logic [DATA_WIDTH-1:0]          ImmOp,
    output logic                           halted,
    output logic                           illegal
`ifdef PC_CTRL_INSTR_COUNT_EN
    ,
    output logic [31:0]                    retired
`endif
);

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  is_add;
    logic                  is_sub;
    logic                  is_addi;
    logic                  is_bne;
    logic                  is_ebreak;
    logic                  is_legal;
    logic                  in_run;
    logic [12:0]           b_imm;
    logic [DATA_WIDTH-1:0] i_imm_ext;
    logic [DATA_WIDTH-1:0] b_imm_ext;
    logic [ADDR_WIDTH-1:0] b_offset;
    logic [ADDR_WIDTH-1:0] next_pc;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign in_run    = (state == RUN);

    assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_bne    = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign is_ebreak = (instr == DATA_WIDTH'(32'h0010_0073));
    assign is_legal  = is_add || is_sub || is_addi || is_bne || is_ebreak;

    // B-type offset is scattered across the word; bit 0 is always zero.
    assign b_imm     = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign i_imm_ext = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign b_imm_ext = {{(DATA_WIDTH-13){b_imm[12]}}, b_imm};
    assign b_offset  = {{(ADDR_WIDTH-13){b_imm[12]}}, b_imm};

    // Zero only matters while a BNE is on the instruction bus.
    assign next_pc = (is_bne && !Zero) ? (pc + b_offset) : (pc + ADDR_WIDTH'(4));

    always_comb begin
        AD1     = '0;
        AD2     = '0;
        AD3     = '0;
        WE3     = 1'b0;
        ALUsrc  = 1'b0;
        ALUctrl = 1'b0;
        ImmOp   = '0;
        if (in_run) begin
            AD1 = REG_FILE_ADDR_WIDTH'(instr[19:15]);
            AD2 = REG_FILE_ADDR_WIDTH'(instr[24:20]);
            AD3 = REG_FILE_ADDR_WIDTH'(instr[11:7]);
            if (is_add) begin
                WE3 = 1'b1;
            end else if (is_sub) begin
                WE3     = 1'b1;
                ALUctrl = 1'b1;
            end else if (is_addi) begin
                WE3    = 1'b1;
                ALUsrc = 1'b1;
                ImmOp  = i_imm_ext;
            end else if (is_bne) begin
                ALUctrl = 1'b1;
                ImmOp   = b_imm_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= START;
            pc      <= RESET_VECTOR;
            halted  <= 1'b0;
            illegal <= 1'b0;
`ifdef PC_CTRL_INSTR_COUNT_EN
            retired <= '0;
`endif
        end else begin
            case (state)
                START: state <= RUN;
                RUN: begin
                    if (is_ebreak) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc <= next_pc;
                        if (!is_legal) begin
                            illegal <= 1'b1;
                        end
`ifdef PC_CTRL_INSTR_COUNT_EN
                        retired <= retired + 32'd1;
`endif
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Scoreboard bench for pc_ctrl_unit: a kind-level reference model queues expected outputs per cycle,
// a negedge monitor pops and compares. A second instance checks PC wrap from RESET_VECTOR 0xFFFFFFFC.
module tb_pc_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic [31:0] pc;
    logic [4:0]  AD1, AD2, AD3;
    logic        WE3, ALUsrc, ALUctrl;
    logic [31:0] ImmOp;
    logic        halted, illegal;

    logic [31:0] pc_w;
    logic [4:0]  ad1_w, ad2_w, ad3_w;
    logic        we3_w, alusrc_w, aluctrl_w;
    logic [31:0] immop_w;
    logic        halted_w, illegal_w;

`ifdef PC_CTRL_INSTR_COUNT_EN
    logic [31:0] retired;
    logic [31:0] retired_w;
`endif

    always #5 clk = ~clk;

    pc_ctrl_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .pc(pc),
        .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
        .ImmOp(ImmOp), .halted(halted), .illegal(illegal)
`ifdef PC_CTRL_INSTR_COUNT_EN
        , .retired(retired)
`endif
    );

    pc_ctrl_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .instr(32'h0000_0013), .Zero(1'b0), .pc(pc_w),
        .AD1(ad1_w), .AD2(ad2_w), .AD3(ad3_w), .WE3(we3_w), .ALUsrc(alusrc_w), .ALUctrl(aluctrl_w),
        .ImmOp(immop_w), .halted(halted_w), .illegal(illegal_w)
`ifdef PC_CTRL_INSTR_COUNT_EN
        , .retired(retired_w)
`endif
    );

    typedef enum { K_ADD, K_SUB, K_ADDI, K_BNE, K_EBREAK, K_BAD } kind_t;
    typedef enum { M_START, M_RUN, M_HALT } mstate_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  ad1, ad2, ad3;
        logic        we3, alusrc, aluctrl;
        logic [31:0] imm;
        logic        halted, illegal;
        logic [31:0] retired;
        bit          check_ad, check_imm, check_alu;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    mstate_t     mstate;
    logic [31:0] mpc;
    logic        mill;
    logic [31:0] mret;
    int          checks = 0;
    int          passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    endtask

    // Drive one instruction for the current cycle, queue what the DUT must show, then advance the model.
    task automatic applyStimulus(input kind_t k, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input int imm, input logic z, input logic [31:0] raw);
        logic [31:0] w;
        logic [12:0] o;
        logic [11:0] i12;
        exp_t        e;
        o   = 13'(imm);
        i12 = 12'(imm);
        case (k)
            K_ADD:    w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB:    w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_ADDI:   w = {i12, rs1, 3'b000, rd, 7'b0010011};
            K_BNE:    w = {o[12], o[10:5], rs2, rs1, 3'b001, o[4:1], o[11], 7'b1100011};
            K_EBREAK: w = 32'h0010_0073;
            default:  w = raw;
        endcase
        instr = w;
        Zero  = z;

        e.pc = mpc; e.halted = (mstate == M_HALT); e.illegal = mill; e.retired = mret;
        e.ad1 = '0; e.ad2 = '0; e.ad3 = '0; e.we3 = 1'b0; e.alusrc = 1'b0; e.aluctrl = 1'b0;
        e.imm = '0; e.check_ad = 1'b1; e.check_imm = 1'b1; e.check_alu = 1'b1;
        if (mstate == M_RUN) begin
            e.ad1 = w[19:15]; e.ad2 = w[24:20]; e.ad3 = w[11:7];
            case (k)
                K_ADD:    begin e.we3 = 1'b1; e.check_imm = 1'b0; end
                K_SUB:    begin e.we3 = 1'b1; e.aluctrl = 1'b1; e.check_imm = 1'b0; end
                K_ADDI:   begin e.we3 = 1'b1; e.alusrc = 1'b1; e.imm = 32'(imm); end
                K_BNE:    begin e.aluctrl = 1'b1; e.imm = 32'(imm); end
                K_EBREAK: begin e.check_imm = 1'b0; e.check_alu = 1'b0; end
                default:  begin e.check_ad = 1'b0; e.check_imm = 1'b0; e.check_alu = 1'b0; end
            endcase
        end
        sb.push_back(e);

        case (mstate)
            M_START: mstate = M_RUN;
            M_RUN: begin
                if (k == K_EBREAK) mstate = M_HALT;
                else begin
                    mret = mret + 32'd1;
                    if (k == K_BAD) mill = 1'b1;
                    mpc = (k == K_BNE && !z) ? mpc + 32'(imm) : mpc + 32'd4;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst    = 1'b0;
        mstate = M_START;
        mpc    = 32'd0;
        mill   = 1'b0;
        mret   = 32'd0;
    endtask

    task automatic randomInstr();
        int          sel;
        int          v;
        logic [31:0] r;
        logic [4:0]  a, b, d;
        sel = int'($urandom_range(0, 99));
        a   = 5'($urandom_range(0, 31));
        b   = 5'($urandom_range(0, 31));
        d   = 5'($urandom_range(0, 31));
        r   = $urandom();
        if (sel < 20)      applyStimulus(K_ADD, a, b, d, 0, r[8], 32'd0);
        else if (sel < 35) applyStimulus(K_SUB, a, b, d, 0, r[8], 32'd0);
        else if (sel < 60) applyStimulus(K_ADDI, a, b, d, int'($urandom_range(0, 4095)) - 2048, r[8], 32'd0);
        else if (sel < 85) applyStimulus(K_BNE, a, b, d, (int'($urandom_range(0, 4095)) - 2048) * 2, r[8], 32'd0);
        else begin
            v = int'($urandom_range(0, 3));
            case (v)
                0:       applyStimulus(K_BAD, a, b, d, 0, r[8], {r[31:7], 7'b0000011});
                1:       applyStimulus(K_BAD, a, b, d, 0, r[8], 32'hFFFF_FFFF);
                2:       applyStimulus(K_BAD, a, b, d, 0, r[8], {7'b0000001, b, a, 3'b000, d, 7'b0110011});
                default: applyStimulus(K_BAD, a, b, d, 0, r[8], {r[31:20], a, 3'b111, d, 7'b0010011});
            endcase
        end
    endtask

    // Monitor: every mid-cycle with a queued expectation, compare the DUT's presented outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checkOutput("pc", pc, mon_e.pc);
                checkOutput("WE3", 32'(WE3), 32'(mon_e.we3));
                checkOutput("halted", 32'(halted), 32'(mon_e.halted));
                checkOutput("illegal", 32'(illegal), 32'(mon_e.illegal));
`ifdef PC_CTRL_INSTR_COUNT_EN
                checkOutput("retired", retired, mon_e.retired);
`endif
                if (mon_e.check_alu) begin
                    checkOutput("ALUsrc", 32'(ALUsrc), 32'(mon_e.alusrc));
                    checkOutput("ALUctrl", 32'(ALUctrl), 32'(mon_e.aluctrl));
                end
                if (mon_e.check_ad) begin
                    checkOutput("AD1", 32'(AD1), 32'(mon_e.ad1));
                    checkOutput("AD2", 32'(AD2), 32'(mon_e.ad2));
                    checkOutput("AD3", 32'(AD3), 32'(mon_e.ad3));
                end
                if (mon_e.check_imm) checkOutput("ImmOp", ImmOp, mon_e.imm);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; instr = 32'h0000_0013; Zero = 1'b0;
        mstate = M_START; mpc = 32'd0; mill = 1'b0; mret = 32'd0;
        doReset(2);

        checkOutput("wrap_start_pc", pc_w, 32'hFFFF_FFFC);
        applyStimulus(K_ADDI, 5'd0, 5'd0, 5'd10, 5, 1'b0, 32'd0);
        checkOutput("wrap_run_pc", pc_w, 32'hFFFF_FFFC);
        applyStimulus(K_ADDI, 5'd0, 5'd0, 5'd10, 5, 1'b0, 32'd0);
        checkOutput("wrap_pc", pc_w, 32'd0);
        applyStimulus(K_ADDI, 5'd0, 5'd0, 5'd10, -1, 1'b0, 32'd0);
        applyStimulus(K_BNE, 5'd10, 5'd0, 5'd0, -4, 1'b0, 32'd0);
        applyStimulus(K_ADD, 5'd10, 5'd10, 5'd11, 0, 1'b1, 32'd0);
        applyStimulus(K_BNE, 5'd10, 5'd0, 5'd0, -4, 1'b1, 32'd0);
        applyStimulus(K_SUB, 5'd3, 5'd4, 5'd5, 0, 1'b0, 32'd0);
        applyStimulus(K_EBREAK, 5'd0, 5'd0, 5'd0, 0, 1'b0, 32'd0);
        repeat (5) applyStimulus(K_ADDI, 5'd0, 5'd0, 5'd10, 5, 1'b0, 32'd0);

        doReset(1);
        applyStimulus(K_ADDI, 5'd0, 5'd0, 5'd10, 5, 1'b0, 32'd0);
        repeat (8) applyStimulus(K_ADDI, 5'd0, 5'd0, 5'd0, 0, 1'b0, 32'd0);
        applyStimulus(K_BAD, 5'd0, 5'd0, 5'd0, 0, 1'b0, 32'hFFFF_FFFF);
        repeat (3) applyStimulus(K_BNE, 5'd1, 5'd2, 5'd0, 0, 1'b0, 32'd0);
        repeat (2) applyStimulus(K_ADDI, 5'd1, 5'd0, 5'd2, 7, 1'b0, 32'd0);

        for (int r = 0; r < 6; r++) begin
            doReset(1 + (r % 2));
            randomInstr();
            repeat (50) randomInstr();
            applyStimulus(K_EBREAK, 5'd0, 5'd0, 5'd0, 0, 1'b0, 32'd0);
            repeat (3) randomInstr();
        end

        @(negedge clk);
        repeat (2) @(posedge clk);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl_unit.md
Name: pc_ctrl_unit

Overview:
- Front end of the single-cycle datapath, directly upstream of the register-file/ALU execute stage.
- Holds the program counter and presents it to the combinational instruction ROM.
- Decodes the returned instruction into the execute stage's controls: AD1/AD2/AD3, WE3, ALUsrc, ALUctrl, ImmOp.
- Consumes the execute stage's Zero flag to resolve BNE, and provides start-up and halt sequencing.

Parameters:
- ADDR_WIDTH, 32, program counter width.
- REG_FILE_ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, instruction and immediate width.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  DATA_WIDTH  instruction word from the combinational ROM at address pc, same cycle.
- Zero  in  1  execute-stage flag: ALU result is 0.
- pc  out  ADDR_WIDTH  current program counter.
- AD1  out  REG_FILE_ADDR_WIDTH  rs1 field, instr[19:15].
- AD2  out  REG_FILE_ADDR_WIDTH  rs2 field, instr[24:20].
- AD3  out  REG_FILE_ADDR_WIDTH  rd field, instr[11:7].
- WE3  out  1  register write enable.
- ALUsrc  out  1  1 selects ImmOp as ALU operand 2; 0 selects RD2.
- ALUctrl  out  1  0 = add, 1 = subtract.
- ImmOp  out  DATA_WIDTH  sign-extended immediate (signed).
- halted  out  1  core has stopped.
- illegal  out  1  sticky flag: an unsupported instruction was seen.

Behaviour:
- FSM states and transitions:
  - START: entered on reset. Exactly one cycle, then RUN.
  - RUN: normal execution. Goes to HALT when EBREAK (0x00100073) is decoded.
  - HALT: terminal; left only by rst.
- rst sampled high (including mid-run or in HALT): next edge gives pc=RESET_VECTOR, state=START, halted=0, illegal=0.
- Control outputs in START and HALT: AD1/AD2/AD3/ImmOp=0, WE3=0, ALUsrc=0, ALUctrl=0; pc holds.
- Decode in RUN is combinational from instr, zero latency:
  - ADD (opcode 0110011, f3 000, f7 0000000): WE3=1, ALUsrc=0, ALUctrl=0.
  - SUB (opcode 0110011, f3 000, f7 0100000): WE3=1, ALUsrc=0, ALUctrl=1.
  - ADDI (opcode 0010011, f3 000): WE3=1, ALUsrc=1, ALUctrl=0, ImmOp=sext(instr[31:20]).
  - BNE (opcode 1100011, f3 001): WE3=0, ALUsrc=0, ALUctrl=1, ImmOp=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - EBREAK: WE3=0, pc holds, halted=1 from the next cycle.
  - Anything else: NOP (WE3=0), illegal set at the next edge, pc advances.
- AD1/AD2/AD3 follow the raw instruction fields for all decoded instructions. WE3=0 makes AD3 harmless.
- Next PC in RUN:
  - BNE with Zero=0: pc+ImmOp (taken).
  - BNE with Zero=1, and all other non-halting instructions: pc+4.
- PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFFFFFC+4 wraps to 0.
- Branch to self (offset 0, taken) is legal: it loops and does not halt.
- Zero is read only while a BNE is being decoded and is ignored otherwise.

Optional Feature:
- Macro: PC_CTRL_INSTR_COUNT_EN.
- When defined:
  - Extra output retired, 32 bits.
  - Increments at each RUN-cycle edge whose instruction is not EBREAK; illegal NOPs count.
  - Cleared by rst, wraps at 2^32, frozen in START and HALT.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
1. Reset sequence: rst=1 for 2 cycles, then release.
   - pc=0 during the START cycle and the first RUN cycle.
   - WE3=0 in START; halted=0; illegal=0.
2. ADDI x10,x0,5 (0x00500513) in RUN.
   - Required outputs: AD1=0, AD3=10, WE3=1, ALUsrc=1, ALUctrl=0, ImmOp=5.
   - Next pc=pc+4.
3. Immediate and register-format decode:
   - ADDI imm -1 (0xFFF00513): ImmOp=0xFFFFFFFF.
   - ADD x11,x10,x10 (0x00A505B3): AD1=AD2=10, AD3=11, ALUsrc=0, ALUctrl=0, WE3=1.
4. BNE x10,x0,-4 (0xFE051EE3) at pc=8.
   - ImmOp=0xFFFFFFFC, WE3=0, ALUctrl=1.
   - Zero=0: next pc=4. Zero=1: next pc=12.
5. EBREAK at pc=0x10.
   - halted=1 next cycle; pc stays 0x10.
   - WE3=0 for 5 cycles while instr is driven with ADDI.
   - Then rst: pc=0, halted=0.
6. Illegal instruction and wrap:
   - 0xFFFFFFFF at pc=0x20: WE3=0, illegal=1 next cycle and stays 1, pc=0x24.
   - Separately, after reset to pc=0xFFFFFFFC with a NOP-equivalent ADDI: pc wraps to 0.
